// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard unit: FSM states and operand forward-select codes.
package hazard_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_MEM_WAIT = 2'b01,
      ST_LONG     = 2'b10
   } hz_state_t;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/hazard_ctrl_fwd_select.sv
// Single-operand bypass select for the E stage; the younger M result wins over W.
module fwd_select
   import hazard_pkg::*;
#(
   parameter int REG_W = 4
) (
   input  logic [REG_W-1:0] src_reg,
   input  logic             src_valid,
   input  logic [REG_W-1:0] dst_regM,
   input  logic             reg_writeM,
   input  logic [REG_W-1:0] dst_regW,
   input  logic             reg_writeW,
   output logic [1:0]       fwd
);

   // Priority compare against the M then W destination.
   always_comb begin
      fwd = FWD_RF;
      if (src_valid && reg_writeM && (src_reg == dst_regM)) begin
         fwd = FWD_M;
      end else if (src_valid && reg_writeW && (src_reg == dst_regW)) begin
         fwd = FWD_W;
      end else begin
         fwd = FWD_RF;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use interlock, memory-wait and
// long-operation stalls, mispredict flushes and a saturating stalled-cycle counter.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int NUM_SRC  = 4,
   parameter int REG_W    = 4,
   parameter int LONG_LAT = 4,
   parameter int CNT_W    = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_SRC*REG_W-1:0] src_regD,
   input  logic [NUM_SRC-1:0]       src_validD,
   input  logic [NUM_SRC*REG_W-1:0] src_regE,
   input  logic [NUM_SRC-1:0]       src_validE,
   input  logic [REG_W-1:0]         dst_regE,
   input  logic [REG_W-1:0]         dst_regM,
   input  logic [REG_W-1:0]         dst_regW,
   input  logic                     reg_writeE,
   input  logic                     reg_writeM,
   input  logic                     reg_writeW,
   input  logic                     mem_to_regE,
   input  logic                     mem_to_regM,
   input  logic                     mem_readyM,
   input  logic                     long_startE,
   input  logic                     wrong_predictionE,
   output logic [2*NUM_SRC-1:0]     forwardE,
   output logic                     stallF,
   output logic                     stallD,
   output logic                     stallE,
   output logic                     stallM,
   output logic                     flushD,
   output logic                     flushE,
   output logic                     busy,
   output logic [CNT_W-1:0]         stall_cnt
);

   localparam logic [3:0]       LONG_LOAD = 4'(LONG_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   hz_state_t              state_r;
   logic [3:0]             lcnt_r;
   logic [CNT_W-1:0]       stall_cnt_r;
   logic [2*NUM_SRC-1:0]   fwd_s;
   logic                   mem_wait_s;
   logic                   ld_hit_s;
   logic                   ld_stall_s;
   logic                   long_go_s;
   logic                   stall_f_s, stall_d_s, stall_e_s, stall_m_s;
   logic                   flush_d_s, flush_e_s;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
      fwd_select #(.REG_W(REG_W)) u_fwd (
         .src_reg    (src_regE[g*REG_W +: REG_W]),
         .src_valid  (src_validE[g]),
         .dst_regM   (dst_regM),
         .reg_writeM (reg_writeM),
         .dst_regW   (dst_regW),
         .reg_writeW (reg_writeW),
         .fwd        (fwd_s[2*g +: 2])
      );
   end

   assign mem_wait_s = mem_to_regM & ~mem_readyM;
   // A long op only launches from RUN with E actually advancing into the multiplier.
   assign long_go_s  = (state_r == ST_RUN) & long_startE & ~mem_wait_s;

   // Load-use compare of every D operand against the load in E.
   always_comb begin
      ld_hit_s = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         ld_hit_s = ld_hit_s | (src_validD[i] & (src_regD[i*REG_W +: REG_W] == dst_regE));
      end
      ld_stall_s = reg_writeE & mem_to_regE & ld_hit_s;
   end

   // Raw stall decode by state, then flush/stall arbitration.
   always_comb begin
      stall_f_s = 1'b0;
      stall_d_s = 1'b0;
      stall_e_s = 1'b0;
      stall_m_s = 1'b0;
      case (state_r)
         ST_RUN, ST_MEM_WAIT: begin
            if (mem_wait_s) begin
               {stall_f_s, stall_d_s, stall_e_s, stall_m_s} = 4'b1111;
            end else if (long_go_s) begin
               {stall_f_s, stall_d_s, stall_e_s, stall_m_s} = 4'b1110;
            end else begin
               {stall_f_s, stall_d_s, stall_e_s, stall_m_s} = {ld_stall_s, ld_stall_s, 2'b00};
            end
         end
         ST_LONG: begin
            {stall_f_s, stall_d_s, stall_e_s, stall_m_s} = {3'b111, mem_wait_s};
         end
         default: begin
            {stall_f_s, stall_d_s, stall_e_s, stall_m_s} = 4'b0000;
         end
      endcase
      // A mispredict under a held E is deferred until E moves.
      flush_d_s = wrong_predictionE & ~stall_e_s;
      flush_e_s = (ld_stall_s | wrong_predictionE) & ~stall_e_s;
      if (flush_d_s) begin
         stall_d_s = 1'b0;
      end else begin
         stall_d_s = stall_d_s;
      end
   end

   // Output drive, forced quiet while reset is held.
   always_comb begin
      if (reset) begin
         forwardE = {(2*NUM_SRC){1'b0}};
         {stallF, stallD, stallE, stallM} = 4'b0000;
         {flushD, flushE} = 2'b00;
         busy = 1'b0;
      end else begin
         forwardE = fwd_s;
         {stallF, stallD, stallE, stallM} = {stall_f_s, stall_d_s, stall_e_s, stall_m_s};
         {flushD, flushE} = {flush_d_s, flush_e_s};
         busy = (state_r != ST_RUN);
      end
   end

   assign stall_cnt = stall_cnt_r;

   // Hazard FSM and long-op countdown; a memory wait freezes the countdown.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_RUN;
         lcnt_r  <= 4'd0;
      end else begin
         case (state_r)
            ST_RUN: begin
               if (mem_wait_s) begin
                  state_r <= ST_MEM_WAIT;
               end else if (long_go_s) begin
                  state_r <= ST_LONG;
                  lcnt_r  <= LONG_LOAD;
               end else begin
                  state_r <= ST_RUN;
               end
            end
            ST_MEM_WAIT: begin
               if (!mem_wait_s) begin
                  state_r <= ST_RUN;
               end else begin
                  state_r <= ST_MEM_WAIT;
               end
            end
            ST_LONG: begin
               if (mem_wait_s) begin
                  lcnt_r <= lcnt_r;
               end else if (lcnt_r <= 4'd1) begin
                  state_r <= ST_RUN;
                  lcnt_r  <= 4'd0;
               end else begin
                  lcnt_r <= lcnt_r - 4'd1;
               end
            end
            default: begin
               state_r <= ST_RUN;
               lcnt_r  <= 4'd0;
            end
         endcase
      end
   end

   // Saturating count of cycles in which fetch was held.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_r <= {CNT_W{1'b0}};
      end else if (stallF && (stall_cnt_r != CNT_MAX)) begin
         stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a cycle-level reference model and literal spot checks.
module tb_hazard_ctrl;

   localparam int NS   = 4;
   localparam int RW   = 4;
   localparam int LAT  = 4;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic            clk = 1'b0;
   logic            reset;
   logic [NS*RW-1:0] src_regD, src_regE;
   logic [NS-1:0]   src_validD, src_validE;
   logic [RW-1:0]   dst_regE, dst_regM, dst_regW;
   logic            reg_writeE, reg_writeM, reg_writeW;
   logic            mem_to_regE, mem_to_regM, mem_readyM;
   logic            long_startE, wrong_predictionE;
   logic [2*NS-1:0] forwardE;
   logic            stallF, stallD, stallE, stallM, flushD, flushE, busy;
   logic [CW-1:0]   stall_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   hazard_ctrl #(.NUM_SRC(NS), .REG_W(RW), .LONG_LAT(LAT), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset),
      .src_regD(src_regD), .src_validD(src_validD),
      .src_regE(src_regE), .src_validE(src_validE),
      .dst_regE(dst_regE), .dst_regM(dst_regM), .dst_regW(dst_regW),
      .reg_writeE(reg_writeE), .reg_writeM(reg_writeM), .reg_writeW(reg_writeW),
      .mem_to_regE(mem_to_regE), .mem_to_regM(mem_to_regM), .mem_readyM(mem_readyM),
      .long_startE(long_startE), .wrong_predictionE(wrong_predictionE),
      .forwardE(forwardE),
      .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
      .flushD(flushD), .flushE(flushE), .busy(busy), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: remaining long-op cycles, memory-wait flag, stalled-cycle tally.
   int   m_left = 0, n_left = 0;
   bit   m_wait = 0, n_wait = 0;
   int   m_cnt  = 0, n_cnt  = 0;
   logic e_mw, e_ld, e_lact, e_start, e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_busy;
   logic [2*NS-1:0] e_fwd;

   always @(negedge clk) begin
      e_mw = mem_to_regM && !mem_readyM;
      e_ld = 1'b0;
      for (int i = 0; i < NS; i++)
         if (src_validD[i] && src_regD[i*RW +: RW] == dst_regE) e_ld = 1'b1;
      e_ld = e_ld && reg_writeE && mem_to_regE;
      for (int i = 0; i < NS; i++) begin
         if (src_validE[i] && reg_writeM && src_regE[i*RW +: RW] == dst_regM) e_fwd[2*i +: 2] = 2'd2;
         else if (src_validE[i] && reg_writeW && src_regE[i*RW +: RW] == dst_regW) e_fwd[2*i +: 2] = 2'd1;
         else e_fwd[2*i +: 2] = 2'd0;
      end
      e_lact  = (m_left > 0);
      e_start = !e_lact && !m_wait && !e_mw && long_startE;
      if (e_mw) {e_sf, e_sd, e_se, e_sm} = 4'b1111;
      else if (e_lact || e_start) {e_sf, e_sd, e_se, e_sm} = 4'b1110;
      else {e_sf, e_sd, e_se, e_sm} = {e_ld, e_ld, 2'b00};
      e_fd = wrong_predictionE && !e_se;
      e_fe = (e_ld || wrong_predictionE) && !e_se;
      if (e_fd) e_sd = 1'b0;
      e_busy = m_wait || e_lact;
      if (reset) begin
         e_fwd = '0;
         {e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_busy} = 7'b0;
         chk("model_cnt", 32'(stall_cnt), 32'd0);
         n_left = 0; n_wait = 0; n_cnt = 0;
      end else begin
         chk("model_cnt", 32'(stall_cnt), 32'(m_cnt));
         n_wait = e_mw && !e_lact;
         if (e_lact) n_left = e_mw ? m_left : m_left - 1;
         else n_left = e_start ? LAT - 1 : 0;
         n_cnt = (e_sf && m_cnt < CMAX) ? m_cnt + 1 : m_cnt;
      end
      chk("model_fwd", 32'(forwardE), 32'(e_fwd));
      chk("model_stall", {28'd0, stallF, stallD, stallE, stallM}, {28'd0, e_sf, e_sd, e_se, e_sm});
      chk("model_flush", {30'd0, flushD, flushE}, {30'd0, e_fd, e_fe});
      chk("model_busy", 32'(busy), 32'(e_busy));
   end

   always @(posedge clk) begin
      if (reset) begin
         m_left <= 0; m_wait <= 0; m_cnt <= 0;
      end else begin
         m_left <= n_left; m_wait <= n_wait; m_cnt <= n_cnt;
      end
   end

   task automatic idle();
      src_regD = '0; src_validD = '0; src_regE = '0; src_validE = '0;
      dst_regE = '0; dst_regM = '0; dst_regW = '0;
      {reg_writeE, reg_writeM, reg_writeW} = 3'b000;
      {mem_to_regE, mem_to_regM, mem_readyM} = 3'b000;
      long_startE = 1'b0; wrong_predictionE = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic stalls(input string name, input logic [3:0] exp);
      chk(name, {28'd0, stallF, stallD, stallE, stallM}, {28'd0, exp});
   endtask

   initial begin
      idle();
      reset = 1'b1;
      tick();
      // Active hazards while reset is held must not reach the outputs.
      src_regE[3:0] = 4'd3; src_validE[0] = 1'b1; dst_regM = 4'd3; reg_writeM = 1'b1;
      mem_to_regM = 1'b1; long_startE = 1'b1; wrong_predictionE = 1'b1;
      @(negedge clk);
      chk("rst_fwd", 32'(forwardE), 32'd0);
      stalls("rst_stalls", 4'b0000);
      chk("rst_flush", {30'd0, flushD, flushE}, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cnt", 32'(stall_cnt), 32'd0);
      tick(); idle(); reset = 1'b0;

      // Forwarding priority.
      src_regE[3:0] = 4'd3; src_validE[0] = 1'b1;
      dst_regM = 4'd3; dst_regW = 4'd3; reg_writeM = 1'b1; reg_writeW = 1'b1;
      src_regE[15:12] = 4'd3;
      @(negedge clk);
      chk("fwd_m_prio", 32'(forwardE[1:0]), 32'd2);
      chk("fwd_invalid_op", 32'(forwardE[7:6]), 32'd0);
      tick(); reg_writeM = 1'b0;
      @(negedge clk);
      chk("fwd_w", 32'(forwardE[1:0]), 32'd1);
      tick(); reg_writeW = 1'b0;
      @(negedge clk);
      chk("fwd_rf", 32'(forwardE[1:0]), 32'd0);

      // Load-use interlock.
      tick(); idle();
      reg_writeE = 1'b1; mem_to_regE = 1'b1; dst_regE = 4'd5;
      src_regD[11:8] = 4'd5; src_validD[2] = 1'b1;
      @(negedge clk);
      stalls("lu_stall", 4'b1100);
      chk("lu_flushE", 32'(flushE), 32'd1);
      tick(); idle();
      @(negedge clk);
      stalls("lu_released", 4'b0000);
      chk("lu_cnt", 32'(stall_cnt), 32'd1);
      tick();
      reg_writeE = 1'b1; mem_to_regE = 1'b1; dst_regE = 4'd5; src_regD[11:8] = 4'd5;
      @(negedge clk);
      stalls("lu_invalid_src", 4'b0000);

      // Memory wait for three cycles.
      tick(); idle(); mem_to_regM = 1'b1;
      @(negedge clk);
      stalls("mw_c1", 4'b1111);
      for (int c = 2; c <= 3; c++) begin
         tick();
         @(negedge clk);
         stalls("mw_cn", 4'b1111);
         chk("mw_busy", 32'(busy), 32'd1);
      end
      tick(); mem_readyM = 1'b1;
      @(negedge clk);
      stalls("mw_ready", 4'b0000);
      chk("mw_cnt", 32'(stall_cnt), 32'd4);
      tick(); idle();
      @(negedge clk);
      chk("mw_done_busy", 32'(busy), 32'd0);

      // Long op of LAT cycles.
      tick(); long_startE = 1'b1;
      for (int c = 0; c < LAT; c++) begin
         @(negedge clk);
         stalls("long_cyc", 4'b1110);
         tick(); long_startE = 1'b0;
      end
      @(negedge clk);
      stalls("long_done", 4'b0000);
      chk("long_cnt", 32'(stall_cnt), 32'd8);

      // Mispredict during a memory wait is deferred.
      tick(); mem_to_regM = 1'b1; wrong_predictionE = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("defer_flush", {30'd0, flushD, flushE}, 32'd0);
         tick();
      end
      mem_readyM = 1'b1;
      @(negedge clk);
      chk("defer_fire", {30'd0, flushD, flushE}, 32'd3);
      chk("defer_cnt", 32'(stall_cnt), 32'd10);

      // Load-use together with a mispredict: D is flushed, not held.
      tick(); idle();
      reg_writeE = 1'b1; mem_to_regE = 1'b1; dst_regE = 4'd9;
      src_regD[3:0] = 4'd9; src_validD[0] = 1'b1; wrong_predictionE = 1'b1;
      @(negedge clk);
      stalls("lu_wp_stall", 4'b1000);
      chk("lu_wp_flush", {30'd0, flushD, flushE}, 32'd3);

      // Memory wait inside a long op stretches it and saturates the counter.
      tick(); idle(); long_startE = 1'b1;
      tick(); idle(); mem_to_regM = 1'b1;
      @(negedge clk);
      stalls("long_mw", 4'b1111);
      chk("long_mw_busy", 32'(busy), 32'd1);
      tick(); tick(); idle();
      repeat (3) tick();
      @(negedge clk);
      stalls("long_mw_done", 4'b0000);
      chk("cnt_saturated", 32'(stall_cnt), 32'd15);

      // Reset in the second cycle of a long op.
      tick(); long_startE = 1'b1;
      tick(); long_startE = 1'b0;
      #1 reset = 1'b1;
      #1;
      stalls("rst_long_stalls", 4'b0000);
      chk("rst_long_busy", 32'(busy), 32'd0);
      chk("rst_long_cnt", 32'(stall_cnt), 32'd0);
      tick(); reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         stalls("post_rst", 4'b0000);
         chk("post_rst_busy", 32'(busy), 32'd0);
         tick();
      end

      repeat (2) tick();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL take parameter NUM_SRC, default 4: number of source operands per instruction.
REQ-002 SHALL take parameter REG_W, default 4: register index width.
REQ-003 SHALL take parameter LONG_LAT, default 4, legal range 2..15: execute cycles of a long (mul/div) operation.
REQ-004 SHALL take parameter CNT_W, default 16: stall-counter width.
REQ-005 Ports SHALL be, in this order:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- src_regD  in  NUM_SRC*REG_W  D-stage source indices; operand i in bits [i*REG_W +: REG_W].
- src_validD  in  NUM_SRC  D source i is read.
- src_regE  in  NUM_SRC*REG_W  E-stage source indices.
- src_validE  in  NUM_SRC  E source i is read.
- dst_regE, dst_regM, dst_regW  in  REG_W each  destination index per stage.
- reg_writeE, reg_writeM, reg_writeW  in  1 each  stage writes a register.
- mem_to_regE  in  1  E instruction is a load.
- mem_to_regM  in  1  M instruction is a load.
- mem_readyM  in  1  data-memory handshake; load data valid this cycle.
- long_startE  in  1  E instruction is a long operation.
- wrong_predictionE  in  1  branch resolved mispredicted in E.
- forwardE  out  2*NUM_SRC  per-operand select: 00 = register file, 01 = W, 10 = M.
- stallF, stallD, stallE, stallM  out  1 each  hold the stage register.
- flushD, flushE  out  1 each  bubble the stage register.
- busy  out  1  FSM not in RUN.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

Function
REQ-006 forwardE[i] SHALL be 10 when src_validE[i], reg_writeM and src_regE[i]==dst_regM; else 01 when src_validE[i], reg_writeW and src_regE[i]==dst_regW; else 00. M has priority over W. The output is combinational with 0-cycle latency.
REQ-007 ld_stall SHALL be asserted (combinational) when reg_writeE, mem_to_regE and any i has src_validD[i] with src_regD[i]==dst_regE.
REQ-008 The FSM SHALL have three states: RUN, MEM_WAIT and LONG.
REQ-009 RUN to MEM_WAIT SHALL occur when mem_to_regM & !mem_readyM.
REQ-010 RUN to LONG SHALL occur when long_startE and the MEM_WAIT condition is false. On this transition the counter loads LONG_LAT-1.
REQ-011 MEM_WAIT to RUN SHALL occur on the first cycle mem_readyM=1.
REQ-012 LONG SHALL decrement the counter each cycle and move to RUN on the cycle it reads 1.
REQ-013 The mem-wait condition (mem_to_regM & !mem_readyM) SHALL be honoured combinationally in any state.
- In RUN and MEM_WAIT it asserts stallF, stallD, stallE and stallM in the same cycle.
- In LONG it additionally holds the counter; the state stays LONG.
REQ-014 In LONG (counter > 1) and in the RUN cycle that enters LONG, stallF, stallD and stallE SHALL be 1 and stallM SHALL be 0.
REQ-015 In RUN with no mem-wait or long condition, stallF = stallD = ld_stall, and stallE = stallM = 0.
REQ-016 flushE SHALL be (ld_stall | wrong_predictionE) & !stallE.
REQ-017 flushD SHALL be wrong_predictionE & !stallE.
- A mispredict under a stall is therefore deferred until E advances.
REQ-018 When flushD=1, stallD SHALL be 0.
REQ-019 busy SHALL be 1 in MEM_WAIT and LONG.
REQ-020 stall_cnt SHALL increment on each cycle where stallF=1 and SHALL saturate at all-ones.
REQ-021 long_startE SHALL be ignored while stallE=1 and while in LONG.

Reset
REQ-022 While reset=1, the state SHALL be RUN, the long counter 0 and stall_cnt 0.
REQ-023 While reset=1, forwardE, all stall and flush outputs, and busy SHALL read 0.
REQ-024 Reset asserted mid-MEM_WAIT or mid-LONG SHALL abort that operation immediately, with no residual stall after release.

Structure
REQ-025 A shared package (hazard_pkg) SHALL hold:
- the FSM state enum;
- the forward-select encodings FWD_RF, FWD_W and FWD_M.
REQ-026 Per-operand forwarding logic SHALL be a sub-module, fwd_select, instantiated NUM_SRC times.
REQ-027 The FSM, the counters and the load-use compare SHALL stay in hazard_ctrl.

Verification
REQ-028 Forward priority: src_regE[0]=dst_regM=dst_regW=3, both writes set -> forwardE[1:0]=10. Clear reg_writeM -> 01.
REQ-029 Load-use: mem_to_regE=1, dst_regE=5, src_regD[2]=5 valid -> stallF=stallD=flushE=1 for 1 cycle. The same case with src_validD[2]=0 -> no stall.
REQ-030 Memory wait: mem_to_regM=1, mem_readyM low for 3 cycles -> all four stalls high for 3 cycles, busy=1, stall_cnt+=3, then RUN.
REQ-031 Long op: LONG_LAT=4 and long_startE -> stallF/D/E high for exactly 4 cycles, with stallM=0.
REQ-032 Deferred flush: wrong_predictionE during MEM_WAIT -> flushD=flushE=0 until mem_readyM=1, then 1 in that cycle.
REQ-033 Reset: assert reset in cycle 2 of LONG -> outputs 0 at once, busy=0, and no stall after release.
